// File: rtl/cond_pkg.sv
// cond_pkg -- shared definitions for the conditional-execution sequencer.
//   * 4-bit condition codes carried in ir[31:28]
//   * bit positions inside the {C,N,V,Z} flag nibble
//   * sequencer FSM state encoding
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Flag nibble layout: {C,N,V,Z}
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        EVAL       = 2'd2
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// cond_eval -- combinational condition-code table.
// Ports:
//   cond  in  4  condition code (ir[31:28])
//   flags in  4  {C,N,V,Z}
//   pass  out 1  condition holds; NV (1111) always reports 0
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic c, n, v, z;

    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];
    assign z = flags[FLAG_Z];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;   // NV: never
        endcase
    end

endmodule

// File: rtl/cond_exec_sequencer.sv
// cond_exec_sequencer -- accepts one instruction at a time from the decoder,
// waits for outstanding flag-setting results, then decides execute / squash /
// undefined-trap from the condition field.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ir_valid/ir/ir_ready decoder handshake; cond in ir[31:28]
//   set_flags           accepted instruction will write flags when executed
//   alu_flags(_valid)   {C,N,V,Z} result from the ALU
//   exec_go/squash/undef one-cycle decision pulses (exactly one per instruction)
//   flags_q             architectural flags {C,N,V,Z}
//   stall_cnt           saturating count of WAIT_FLAGS cycles
//
// Build option: COND_NV_TRAP_EN -- when defined, cond 1111 raises undef;
// otherwise it is treated as "never" and squashed, and undef stays 0.
module cond_exec_sequencer
    import cond_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_valid,
    input  logic [31:0] ir,
    output logic        ir_ready,
    input  logic        set_flags,
    input  logic [3:0]  alu_flags,
    input  logic        alu_flags_valid,
    output logic        exec_go,
    output logic        squash,
    output logic        undef,
    output logic [3:0]  flags_q,
    output logic [15:0] stall_cnt
);

    state_e      state_q, state_d;
    logic [3:0]  cond_q, cond_d;
    logic        sf_q, sf_d;
    logic [3:0]  flags_d;
    logic        pend_q, pend_d;
    logic [15:0] stall_q, stall_d;

    logic        pass;
    logic        nv_trap;
    logic        unused_ir;

    // Only the condition field is consumed here.
    assign unused_ir = ^ir[27:0];

    cond_eval u_cond_eval (
        .cond  (cond_q),
        .flags (flags_q),
        .pass  (pass)
    );

`ifdef COND_NV_TRAP_EN
    assign nv_trap = (cond_q == COND_NV);
`else
    assign nv_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cond_q  <= 4'h0;
            sf_q    <= 1'b0;
            flags_q <= 4'h0;
            pend_q  <= 1'b0;
            stall_q <= 16'h0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            sf_q    <= sf_d;
            flags_q <= flags_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cond_d   = cond_q;
        sf_d     = sf_q;
        flags_d  = flags_q;
        pend_d   = pend_q;
        stall_d  = stall_q;
        exec_go  = 1'b0;
        squash   = 1'b0;
        undef    = 1'b0;
        ir_ready = (state_q == IDLE);

        // ALU result only lands while a flag write is outstanding.
        if (alu_flags_valid && pend_q) begin
            flags_d = alu_flags;
            pend_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ir_valid) begin
                    cond_d = ir[31:28];
                    sf_d   = set_flags;
                    // A result arriving on the handshake edge is already in
                    // flags_q when EVAL looks at it.
                    state_d = (!pend_q || alu_flags_valid) ? EVAL : WAIT_FLAGS;
                end
            end
            WAIT_FLAGS: begin
                if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                if (alu_flags_valid) state_d = EVAL;
            end
            EVAL: begin
                state_d = IDLE;
                if (nv_trap) begin
                    undef = 1'b1;
                end else if (pass) begin
                    exec_go = 1'b1;
                    if (sf_q) pend_d = 1'b1;
                end else begin
                    squash = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A held instruction is dropped silently under reset.
        if (reset) begin
            exec_go  = 1'b0;
            squash   = 1'b0;
            undef    = 1'b0;
            ir_ready = 1'b0;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: doc/cond_exec_sequencer.md
COND_EXEC_SEQUENCER -- requirements
Module: cond_exec_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: ir_valid  in  1  decoder offers instruction; ir  in  32  instruction word, cond field ir[31:28]; ir_ready  out  1  sequencer accepts.
REQ-004 SHALL have ports: set_flags  in  1  offered instruction updates flags (S bit), sampled with ir.
REQ-005 SHALL have ports: alu_flags  in  4  {C,N,V,Z} at bits [3:0]; alu_flags_valid  in  1  ALU flag result valid this cycle.
REQ-006 SHALL have ports: exec_go  out  1  one-cycle pulse, execute accepted instruction; squash  out  1  one-cycle pulse, discard it; undef  out  1  one-cycle pulse, cond 1111 trap (config-dependent).
REQ-007 SHALL have ports: flags_q  out  4  architectural flags, same bit order as alu_flags; stall_cnt  out  16  cycles spent waiting on flags.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT_FLAGS, EVAL.
REQ-009 ir_ready SHALL be 1 only in IDLE; handshake = ir_valid & ir_ready at the edge.
REQ-010 On handshake: latch ir[31:28] and set_flags; go to EVAL if flags_pending=0 or alu_flags_valid=1 that cycle, else WAIT_FLAGS.
REQ-011 WAIT_FLAGS: stay until alu_flags_valid=1, then EVAL; stall_cnt increments by 1 per WAIT_FLAGS cycle, saturating at 0xFFFF.
REQ-012 EVAL: exactly one of exec_go/squash/undef pulses for one cycle; then IDLE.
REQ-013 Condition evaluation: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1.
REQ-014 Condition evaluated against flags_q as held in EVAL state (includes any update written on the entering edge).
REQ-015 flags_pending SHALL set on exec_go when latched set_flags=1; squashed/undef instructions never set it.
REQ-016 alu_flags_valid with flags_pending=1: flags_q <= alu_flags and flags_pending <= 0 at that edge.
REQ-017 alu_flags_valid with flags_pending=0: ignored, flags_q unchanged.
REQ-018 Latency: handshake at edge T with no pending flags -> decision pulse in cycle after T; back-to-back throughput one instruction per 2 cycles.
REQ-019 ir/set_flags changes while not in IDLE SHALL have no effect.

Reset
REQ-020 reset SHALL force state IDLE, flags_q=0, flags_pending=0, stall_cnt=0, exec_go=squash=undef=0; ir_ready=1 in the cycle after reset deasserts.
REQ-021 reset mid-WAIT_FLAGS or EVAL SHALL drop the held instruction with no pulse; reset dominates a coincident alu_flags_valid.

Configuration
REQ-022 Macro COND_NV_TRAP_EN defined: cond 1111 in EVAL pulses undef.
REQ-023 COND_NV_TRAP_EN undefined: cond 1111 treated as never -> squash; undef tied to 0.

Structure
REQ-024 Package cond_pkg SHALL hold: 4-bit cond code constants EQ..AL and NV, flag bit indices (C=3,N=2,V=1,Z=0), FSM state enum.
REQ-025 Condition table SHALL be a combinational sub-module cond_eval (inputs cond, flags; output pass), instantiated once.

Verification
REQ-026 Reset, then ir=0xE0000000 (AL), set_flags=0 -> exec_go one cycle after handshake, flags_q=0000.
REQ-027 Accept ir=0xE0100000 with set_flags=1 -> exec_go; then offer ir=0x00000000 (EQ); hold alu_flags_valid low 3 cycles -> stall_cnt=3; then alu_flags=0001 valid -> flags_q=0001, exec_go next cycle.
REQ-028 flags_q=0100 (N=1,V=0): ir cond 1011 (LT) -> exec_go; cond 1010 (GE) -> squash; cond 1101 (LE) -> exec_go.
REQ-029 flags_q=1000 (C=1,Z=0): cond 1000 (HI) -> exec_go, cond 1001 (LS) -> squash; ir cond 1111 -> undef with COND_NV_TRAP_EN, squash without.
REQ-030 Assert reset during WAIT_FLAGS with alu_flags_valid=1 same cycle -> no pulse, flags_q=0, stall_cnt=0, IDLE.
